// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : definitions (package)
//  Description : Shared types and constants for the data-memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package definitions;

    // Responder sequencing: accept, optional wait states, one-cycle response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    // Default number of wait states between acceptance and commit.
    localparam int MEM_WAIT_DEFAULT = 2;

endpackage : definitions
`default_nettype wire

// File: rtl/data_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_array
//  Description : 2^ADDR_W x 8 storage, synchronous write, registered read.
//                Only the read register is reset; contents are not cleared.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    input  logic              we,
    input  logic              re,
    output logic [7:0]        rdata
);

    localparam int c_depth = 1 << ADDR_W;

    logic [7:0] r_mem [c_depth];
    logic [7:0] r_rdata;

    // Storage write port; no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    // Registered read port; holds its value until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 8'h00;
        end else if (re) begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule : data_mem_array
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem
//  Description : Load/store responder with WAIT_CYCLES wait states and a
//                one-cycle ack. Request fields are latched on acceptance.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem
    import definitions::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = MEM_WAIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    input  logic              req,
    input  logic              wr,
    output logic              ack,
    output logic [7:0]        rdata,
    output logic              busy
);

    localparam logic [3:0] c_wait = 4'(WAIT_CYCLES);

    mem_state_t        r_state;
    mem_state_t        w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic              r_wr;

    logic              w_accept;
    logic              w_commit;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [7:0]        w_acc_wdata;
    logic              w_acc_wr;
    logic              w_we;
    logic              w_re;

    // Next-state, counter and access selection. With zero wait states the
    // access happens on the acceptance edge, so the live inputs are used.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        w_acc_addr  = r_addr;
        w_acc_wdata = r_wdata;
        w_acc_wr    = r_wr;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_accept    = 1'b1;
                    w_acc_addr  = addr;
                    w_acc_wdata = wdata;
                    w_acc_wr    = wr;
                    if (c_wait == 4'd0) begin
                        w_commit    = 1'b1;
                        w_state_nxt = RESP;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = c_wait;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_commit    = 1'b1;
                    w_state_nxt = RESP;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State and wait counter; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Request latch; later changes on the inputs are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= 8'h00;
            r_wr    <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_wr    <= wr;
        end
    end

    // Reset on a commit edge suppresses the write.
    assign w_we = w_commit &  w_acc_wr & ~reset;
    assign w_re = w_commit & ~w_acc_wr & ~reset;

    data_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .addr  (w_acc_addr),
        .wdata (w_acc_wdata),
        .we    (w_we),
        .re    (w_re),
        .rdata (rdata)
    );

    assign ack  = (r_state == RESP);
    assign busy = (r_state != IDLE);

endmodule : data_mem
`default_nettype wire

// File: tb/tb_data_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem
//  Description : Self-checking bench for data_mem with 2 and 0 wait states.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] addr_a, wdata_a, rdata_a;
    logic       req_a, wr_a, ack_a, busy_a;
    logic [7:0] addr_z, wdata_z, rdata_z;
    logic       req_z, wr_z, ack_z, busy_z;

    always #5 clk = ~clk;

    data_mem #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset), .addr(addr_a), .wdata(wdata_a), .req(req_a),
        .wr(wr_a), .ack(ack_a), .rdata(rdata_a), .busy(busy_a)
    );

    data_mem #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut_z (
        .clk(clk), .reset(reset), .addr(addr_z), .wdata(wdata_z), .req(req_z),
        .wr(wr_z), .ack(ack_z), .rdata(rdata_z), .busy(busy_z)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] mm [2][256];   // reference memory per instance
    logic [7:0] mr [2];        // reference rdata per instance

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit z, input bit r, input bit w, input logic [7:0] a, input logic [7:0] d);
        if (z) begin
            req_z = r; wr_z = w; addr_z = a; wdata_z = d;
        end else begin
            req_a = r; wr_a = w; addr_a = a; wdata_a = d;
        end
    endtask

    function automatic logic get_ack(input bit z);
        return z ? ack_z : ack_a;
    endfunction

    function automatic logic get_busy(input bit z);
        return z ? busy_z : busy_a;
    endfunction

    function automatic logic [7:0] get_rdata(input bit z);
        return z ? rdata_z : rdata_a;
    endfunction

    // One complete access; mess scrambles addr/wdata/wr after acceptance.
    task automatic access(input bit z, input bit w, input logic [7:0] a, input logic [7:0] d, input bit mess);
        int         lat;
        int         n;
        logic [7:0] a_alt;
        bit         t;
        n     = z ? 0 : 2;
        a_alt = a + 8'd1;
        t     = ~w;
        @(negedge clk);
        drive(z, 1'b1, w, a, d);
        @(negedge clk);
        lat = 1;
        if (mess) drive(z, 1'b1, t, a_alt, ~d);
        while (!get_ack(z) && lat < 20) begin
            @(negedge clk);
            lat++;
            if (mess) begin
                t = ~t;
                drive(z, 1'b1, t, a_alt, ~d);
            end
        end
        chk(z ? "latency_n0" : "latency_n2", lat, n + 1);
        if (w) mm[z][a] = d;
        else   mr[z] = mm[z][a];
        chk(w ? "rdata_after_store" : "rdata_load", {24'h0, get_rdata(z)}, {24'h0, mr[z]});
        chk("busy_in_ack", {31'h0, get_busy(z)}, 32'd1);
        drive(z, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk("busy_after_ack", {31'h0, get_busy(z)}, 32'd0);
        chk("ack_single_pulse", {31'h0, get_ack(z)}, 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         acks;
        logic [7:0] ra, rd;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ack",   {31'h0, ack_a},  32'd0);
        chk("reset_busy",  {31'h0, busy_a}, 32'd0);
        chk("reset_rdata", {24'h0, rdata_a}, 32'd0);
        chk("reset_ack_z",   {31'h0, ack_z},  32'd0);
        chk("reset_busy_z",  {31'h0, busy_z}, 32'd0);
        chk("reset_rdata_z", {24'h0, rdata_z}, 32'd0);
        reset = 1'b0;
        mr[0] = 8'h00;
        mr[1] = 8'h00;

        // Give every location a known value so any load can be checked.
        for (int i = 0; i < 256; i++) begin
            access(1'b0, 1'b1, 8'(i), 8'($urandom), 1'b0);
            access(1'b1, 1'b1, 8'(i), 8'($urandom), 1'b0);
        end

        // Store then load on both instances.
        for (int z = 0; z < 2; z++) begin
            access(z[0], 1'b1, 8'h10, 8'h5A, 1'b0);
            access(z[0], 1'b0, 8'h10, 8'h00, 1'b0);
            chk("store_load_5a", {24'h0, get_rdata(z[0])}, 32'h5A);
        end

        // Input hold-off: scrambled inputs during WAIT must be ignored.
        access(1'b0, 1'b0, 8'h20, 8'h00, 1'b1);
        access(1'b0, 1'b0, 8'h21, 8'h00, 1'b0);

        // Reset during the first WAIT cycle of a store.
        access(1'b0, 1'b1, 8'h30, 8'h77, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 8'h30, 8'hFF);
        @(negedge clk);
        chk("busy_before_abort", {31'h0, busy_a}, 32'd1);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        mr[0] = 8'h00;
        mr[1] = 8'h00;
        chk("abort_busy",  {31'h0, busy_a}, 32'd0);
        chk("abort_rdata", {24'h0, rdata_a}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_ack", {31'h0, ack_a}, 32'd0);
            @(negedge clk);
        end
        access(1'b0, 1'b0, 8'h30, 8'h00, 1'b0);

        // Reset and req in the same cycle: request not accepted.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 8'h40, 8'hAB);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        mr[0] = 8'h00;
        mr[1] = 8'h00;
        chk("reset_req_busy", {31'h0, busy_a}, 32'd0);
        access(1'b0, 1'b0, 8'h40, 8'h00, 1'b0);

        // Back-to-back: req held through ack gives a second access, 1 per 4.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_busy_%0d", i), {31'h0, busy_a}, {31'h0, (i % 4) != 3});
            if (ack_a) acks++;
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        mr[0] = mm[0][8'h10];
        chk("b2b_acks",  acks, 2);
        chk("b2b_rdata", {24'h0, rdata_a}, {24'h0, mr[0]});
        @(negedge clk);
        chk("b2b_idle", {31'h0, busy_a}, 32'd0);

        // Wrap: the top and bottom addresses are distinct locations.
        for (int z = 0; z < 2; z++) begin
            access(z[0], 1'b1, 8'hFF, 8'hC3, 1'b0);
            access(z[0], 1'b1, 8'h00, 8'h3C, 1'b0);
            access(z[0], 1'b0, 8'hFF, 8'h00, 1'b0);
            access(z[0], 1'b0, 8'h00, 8'h00, 1'b0);
        end

        // Random traffic over a narrow window to force address reuse.
        for (int i = 0; i < 120; i++) begin
            ra = 8'($urandom_range(0, 15)) + 8'hF8;
            rd = 8'($urandom);
            access(i[0], 1'($urandom), ra, rd, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_data_mem
`default_nettype wire
